// File: rtl/alu_pkg.sv
// Shared ALU definitions for the decode-to-execute issue stage.
// Holds the 4-bit ALU operation codes, the 2-bit alu_mode codes from decode,
// and the funct3 values that the ALU control decoder recognises.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_SUB = 4'b0000,
    ALU_ADD = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_SRL = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    MODE_ADD   = 2'b00,  // address generation for load/store
    MODE_SUB   = 2'b01,  // branch compare
    MODE_FUNCT = 2'b10,  // decode from funct3/funct7
    MODE_RSVD  = 2'b11
  } alu_mode_e;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SRL    = 3'b101;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

endpackage

// File: rtl/id_ex_alu_issue_if.sv
// Bundle between decode, the ID/EX issue register and the EX stage.
//   id_*   : instruction presented by decode, with id_valid/id_ready handshake
//   fwd_*  : write-back info from EX/MEM and MEM/WB for operand forwarding
//   flush  : kill the registered and the incoming instruction
//   ex_*   : registered instruction for the ALU, with ex_valid/ex_ready handshake
// slave  : the issue register's view; master : the surrounding pipeline's view.
interface id_ex_alu_issue_if #(
  parameter int XLEN = 32,
  parameter int REGW = 5
);
  logic            id_valid;
  logic            id_ready;
  logic [1:0]      id_alu_mode;
  logic [2:0]      id_funct3;
  logic            id_funct7_5;
  logic            id_is_rtype;
  logic            id_alu_src;
  logic [REGW-1:0] id_rs1;
  logic [REGW-1:0] id_rs2;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [REGW-1:0] id_rd;

  logic            fwd_exmem_we;
  logic            fwd_memwb_we;
  logic [REGW-1:0] fwd_exmem_rd;
  logic [REGW-1:0] fwd_memwb_rd;
  logic [XLEN-1:0] fwd_exmem_data;
  logic [XLEN-1:0] fwd_memwb_data;

  logic            flush;

  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_a;
  logic [XLEN-1:0] ex_b;
  logic [3:0]      ex_op;
  logic [XLEN-1:0] ex_store_data;
  logic [REGW-1:0] ex_rd;
  logic            ex_illegal;

  modport slave (
    input  id_valid, id_alu_mode, id_funct3, id_funct7_5, id_is_rtype, id_alu_src,
           id_rs1, id_rs2, id_rs1_data, id_rs2_data, id_imm, id_rd,
           fwd_exmem_we, fwd_memwb_we, fwd_exmem_rd, fwd_memwb_rd,
           fwd_exmem_data, fwd_memwb_data, flush, ex_ready,
    output id_ready, ex_valid, ex_a, ex_b, ex_op, ex_store_data, ex_rd, ex_illegal
  );

  modport master (
    output id_valid, id_alu_mode, id_funct3, id_funct7_5, id_is_rtype, id_alu_src,
           id_rs1, id_rs2, id_rs1_data, id_rs2_data, id_imm, id_rd,
           fwd_exmem_we, fwd_memwb_we, fwd_exmem_rd, fwd_memwb_rd,
           fwd_exmem_data, fwd_memwb_data, flush, ex_ready,
    input  id_ready, ex_valid, ex_a, ex_b, ex_op, ex_store_data, ex_rd, ex_illegal
  );
endinterface

// File: rtl/alu_ctrl_dec.sv
// ALU control decoder (combinational).
//   alu_mode, funct3, funct7_5, is_rtype : decode-stage control fields
//   op      : 4-bit ALU operation code
//   illegal : operation not supported; op falls back to ADD
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [1:0] alu_mode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       is_rtype,
  output alu_op_e    op,
  output logic       illegal
);

  always_comb begin
    // NOTE: both outputs get a default before the case so no path leaves
    // them unassigned; that is what keeps this block free of latches.
    op      = ALU_ADD;
    illegal = 1'b1;
    case (alu_mode)
      MODE_ADD: begin
        op      = ALU_ADD;
        illegal = 1'b0;
      end
      MODE_SUB: begin
        op      = ALU_SUB;
        illegal = 1'b0;
      end
      MODE_FUNCT: begin
        case (funct3)
          F3_ADDSUB: begin
            // Only R-type may encode SUB; ADDI with bit 30 set is still ADD.
            op      = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
            illegal = 1'b0;
          end
          F3_AND: begin
            op      = ALU_AND;
            illegal = 1'b0;
          end
          F3_OR: begin
            op      = ALU_OR;
            illegal = 1'b0;
          end
          F3_SRL: begin
            // Logical shift only; the arithmetic variant falls to the illegal default.
            if (!funct7_5) begin
              op      = ALU_SRL;
              illegal = 1'b0;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX issue register: decodes the ALU control, selects and forwards the
// operands, and registers everything for the EX stage one cycle later.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : decode/forwarding inputs and EX outputs (slave modport)
// One-entry register without skid buffer: decode is accepted when the entry is
// empty or is being consumed in the same cycle. Flush beats accept and hold.
module id_ex_alu_issue
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  id_ex_alu_issue_if.slave    bus
);

  // Forwarding priority: youngest producer (EX/MEM) first. x0 never forwards.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [REGW-1:0] rs,
    input logic [XLEN-1:0] rf_data,
    input logic            exmem_we,
    input logic [REGW-1:0] exmem_rd,
    input logic [XLEN-1:0] exmem_data,
    input logic            memwb_we,
    input logic [REGW-1:0] memwb_rd,
    input logic [XLEN-1:0] memwb_data
  );
    if (exmem_we && exmem_rd == rs && rs != '0) return exmem_data;
    if (memwb_we && memwb_rd == rs && rs != '0) return memwb_data;
    return rf_data;
  endfunction

  alu_op_e         dec_op;
  logic            dec_illegal;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            accept;

  logic            valid_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  alu_op_e         op_q;
  logic [XLEN-1:0] store_q;
  logic [REGW-1:0] rd_q;
  logic            illegal_q;

  alu_ctrl_dec u_dec (
    .alu_mode (bus.id_alu_mode),
    .funct3   (bus.id_funct3),
    .funct7_5 (bus.id_funct7_5),
    .is_rtype (bus.id_is_rtype),
    .op       (dec_op),
    .illegal  (dec_illegal)
  );

  assign rs1_val = fwd_sel(bus.id_rs1, bus.id_rs1_data,
                           bus.fwd_exmem_we, bus.fwd_exmem_rd, bus.fwd_exmem_data,
                           bus.fwd_memwb_we, bus.fwd_memwb_rd, bus.fwd_memwb_data);
  assign rs2_val = fwd_sel(bus.id_rs2, bus.id_rs2_data,
                           bus.fwd_exmem_we, bus.fwd_exmem_rd, bus.fwd_exmem_data,
                           bus.fwd_memwb_we, bus.fwd_memwb_rd, bus.fwd_memwb_data);

  assign bus.id_ready = ~valid_q | bus.ex_ready;
  assign accept       = bus.id_valid & bus.id_ready & ~bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= ALU_ADD;
      store_q   <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
    end else if (bus.flush) begin
      // Data fields keep their old values; only the valid bit is killed.
      valid_q <= 1'b0;
    end else if (accept) begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order.
      valid_q   <= 1'b1;
      a_q       <= rs1_val;
      b_q       <= bus.id_alu_src ? bus.id_imm : rs2_val;
      op_q      <= dec_op;
      store_q   <= rs2_val;
      rd_q      <= bus.id_rd;
      illegal_q <= dec_illegal;
    end else if (bus.ex_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.ex_valid      = valid_q;
  assign bus.ex_a          = a_q;
  assign bus.ex_b          = b_q;
  assign bus.ex_op         = op_q;
  assign bus.ex_store_data = store_q;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_illegal    = illegal_q;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Self-checking bench for id_ex_alu_issue: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_id_ex_alu_issue;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  id_ex_alu_issue_if #(.XLEN(XLEN), .REGW(REGW)) bus ();

  id_ex_alu_issue #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model of the registered EX-side state.
  logic            m_valid;
  logic [XLEN-1:0] m_a, m_b, m_store;
  logic [3:0]      m_op;
  logic [REGW-1:0] m_rd;
  logic            m_illegal;

  task automatic model_reset();
    m_valid = 1'b0; m_a = '0; m_b = '0; m_store = '0;
    m_op = 4'b0001; m_rd = '0; m_illegal = 1'b0;
  endtask

  // Returns {illegal, op} from the operation table.
  function automatic logic [4:0] exp_decode(input logic [1:0] mode, input logic [2:0] f3,
                                            input logic f7, input logic rt);
    if (mode == 2'b00) return 5'b0_0001;
    if (mode == 2'b01) return 5'b0_0000;
    if (mode == 2'b10) begin
      if (f3 == 3'b000) return (rt && f7) ? 5'b0_0000 : 5'b0_0001;
      if (f3 == 3'b111) return 5'b0_0010;
      if (f3 == 3'b110) return 5'b0_0011;
      if (f3 == 3'b101 && !f7) return 5'b0_1100;
    end
    return 5'b1_0001;
  endfunction

  function automatic logic [XLEN-1:0] exp_operand(input logic [REGW-1:0] rs,
                                                  input logic [XLEN-1:0] rf);
    if (rs == 0) return rf;
    if (bus.fwd_exmem_we && bus.fwd_exmem_rd == rs) return bus.fwd_exmem_data;
    if (bus.fwd_memwb_we && bus.fwd_memwb_rd == rs) return bus.fwd_memwb_data;
    return rf;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    logic            can_take;
    logic [4:0]      d;
    logic [XLEN-1:0] v2;
    can_take = !m_valid || bus.ex_ready;
    if (bus.flush) begin
      m_valid = 1'b0;
    end else if (bus.id_valid && can_take) begin
      d         = exp_decode(bus.id_alu_mode, bus.id_funct3, bus.id_funct7_5, bus.id_is_rtype);
      v2        = exp_operand(bus.id_rs2, bus.id_rs2_data);
      m_valid   = 1'b1;
      m_a       = exp_operand(bus.id_rs1, bus.id_rs1_data);
      m_b       = bus.id_alu_src ? bus.id_imm : v2;
      m_store   = v2;
      m_op      = d[3:0];
      m_illegal = d[4];
      m_rd      = bus.id_rd;
    end else if (bus.ex_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("ex_valid",      64'(bus.ex_valid),      64'(m_valid));
    check("ex_a",          64'(bus.ex_a),          64'(m_a));
    check("ex_b",          64'(bus.ex_b),          64'(m_b));
    check("ex_op",         64'(bus.ex_op),         64'(m_op));
    check("ex_illegal",    64'(bus.ex_illegal),    64'(m_illegal));
    check("ex_store_data", 64'(bus.ex_store_data), 64'(m_store));
    check("ex_rd",         64'(bus.ex_rd),         64'(m_rd));
    check("id_ready",      64'(bus.id_ready),      64'(!m_valid || bus.ex_ready));
  endtask

  // Inputs are changed on the falling edge; outputs are sampled there too.
  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_idle();
    bus.id_valid = 1'b0; bus.id_alu_mode = 2'b00; bus.id_funct3 = 3'b000;
    bus.id_funct7_5 = 1'b0; bus.id_is_rtype = 1'b0; bus.id_alu_src = 1'b0;
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rs1_data = '0; bus.id_rs2_data = '0;
    bus.id_imm = '0; bus.id_rd = '0;
    bus.fwd_exmem_we = 1'b0; bus.fwd_memwb_we = 1'b0;
    bus.fwd_exmem_rd = '0; bus.fwd_memwb_rd = '0;
    bus.fwd_exmem_data = '0; bus.fwd_memwb_data = '0;
    bus.flush = 1'b0; bus.ex_ready = 1'b1;
  endtask

  task automatic load_instr(input logic [1:0] mode, input logic [2:0] f3, input logic f7,
                            input logic rt, input logic src, input logic [REGW-1:0] rs1,
                            input logic [REGW-1:0] rs2, input logic [XLEN-1:0] d1,
                            input logic [XLEN-1:0] d2, input logic [XLEN-1:0] imm,
                            input logic [REGW-1:0] rd);
    bus.id_valid = 1'b1; bus.id_alu_mode = mode; bus.id_funct3 = f3;
    bus.id_funct7_5 = f7; bus.id_is_rtype = rt; bus.id_alu_src = src;
    bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rs1_data = d1; bus.id_rs2_data = d2;
    bus.id_imm = imm; bus.id_rd = rd;
  endtask

  task automatic rand_inputs();
    bus.id_valid       = 1'($urandom_range(0, 1));
    bus.id_alu_mode    = 2'($urandom_range(0, 3));
    bus.id_funct3      = 3'($urandom_range(0, 7));
    bus.id_funct7_5    = 1'($urandom_range(0, 1));
    bus.id_is_rtype    = 1'($urandom_range(0, 1));
    bus.id_alu_src     = 1'($urandom_range(0, 1));
    bus.id_rs1         = REGW'($urandom_range(0, 3));
    bus.id_rs2         = REGW'($urandom_range(0, 3));
    bus.id_rs1_data    = $urandom;
    bus.id_rs2_data    = $urandom;
    bus.id_imm         = $urandom;
    bus.id_rd          = REGW'($urandom_range(0, 31));
    bus.fwd_exmem_we   = 1'($urandom_range(0, 1));
    bus.fwd_memwb_we   = 1'($urandom_range(0, 1));
    bus.fwd_exmem_rd   = REGW'($urandom_range(0, 3));
    bus.fwd_memwb_rd   = REGW'($urandom_range(0, 3));
    bus.fwd_exmem_data = $urandom;
    bus.fwd_memwb_data = $urandom;
    bus.flush          = ($urandom_range(0, 7) == 0);
    bus.ex_ready       = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    set_idle();
    model_reset();

    // Reset values.
    #1 rst_n = 1'b0;
    #2 compare_all();
    @(negedge clk) rst_n = 1'b1;

    // R-type SUB.
    load_instr(2'b10, 3'b000, 1'b1, 1'b1, 1'b0, 5'd1, 5'd2, 32'd10, 32'd3, 32'd0, 5'd7);
    step();

    // I-type SRL, then SRA flagged illegal.
    load_instr(2'b10, 3'b101, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 32'h80, 32'h9, 32'd4, 5'd8);
    step();
    bus.id_funct7_5 = 1'b1;
    step();

    // Forwarding priority, then x0 never forwarded.
    load_instr(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 5'd5, 5'd5, 32'h11, 32'h22, 32'd0, 5'd9);
    bus.fwd_exmem_we = 1'b1; bus.fwd_exmem_rd = 5'd5; bus.fwd_exmem_data = 32'hAA;
    bus.fwd_memwb_we = 1'b1; bus.fwd_memwb_rd = 5'd5; bus.fwd_memwb_data = 32'hBB;
    step();
    bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0;
    bus.fwd_exmem_rd = 5'd0; bus.fwd_memwb_rd = 5'd0;
    step();
    bus.fwd_exmem_we = 1'b0;
    bus.id_rs1 = 5'd5; bus.fwd_memwb_rd = 5'd5;
    step();
    set_idle();

    // Stall for 3 cycles with a new instruction waiting, then drain.
    load_instr(2'b10, 3'b111, 1'b0, 1'b1, 1'b0, 5'd3, 5'd4, 32'hF0F0, 32'h0FF0, 32'd0, 5'd10);
    step();
    load_instr(2'b10, 3'b110, 1'b0, 1'b1, 1'b0, 5'd6, 5'd7, 32'h1234, 32'h5678, 32'd0, 5'd11);
    bus.ex_ready = 1'b0;
    repeat (3) step();
    bus.ex_ready = 1'b1;
    step();

    // Flush collides with an acceptable instruction; next idle cycle proves it was dropped.
    load_instr(2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 32'd50, 32'd60, 32'd0, 5'd12);
    bus.flush = 1'b1;
    step();
    set_idle();
    bus.id_valid = 1'b0;
    step();

    // Flush wins over hold.
    load_instr(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 32'd5, 32'd6, 32'd0, 5'd13);
    step();
    set_idle();
    bus.ex_ready = 1'b0; bus.flush = 1'b1;
    step();
    set_idle();

    // Asynchronous reset while holding.
    load_instr(2'b10, 3'b111, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 32'hCAFE, 32'hBEEF, 32'd0, 5'd14);
    step();
    set_idle();
    bus.ex_ready = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst ex_valid", 64'(bus.ex_valid), 64'd0);
    check("async_rst ex_op",    64'(bus.ex_op),    64'h1);
    check("async_rst ex_a",     64'(bus.ex_a),     64'd0);
    @(negedge clk) rst_n = 1'b1;
    compare_all();

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      rand_inputs();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_alu_issue.md
Name: id_ex_alu_issue

Overview:
- Decode-to-execute pipeline register that issues operations to the ALU one stage later.
- Each accepted instruction gets:
  - its ALU control decoded into the 4-bit ALU operation code;
  - operands A/B selected, with forwarding from later stages;
  - everything registered for the EX stage.
- Valid/ready handshake on both sides; supports stall (hold) and flush (bubble).

Parameters:
- XLEN, 32, datapath width of operands and forwarded results.
- REGW, 5, register-index width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode stage presents an instruction.
- id_ready  out  1  this stage accepts the instruction this cycle.
- id_alu_mode  in  2  00=add (load/store), 01=sub (branch compare), 10=funct-decoded, 11=reserved.
- id_funct3  in  3  instruction funct3.
- id_funct7_5  in  1  instruction bit 30.
- id_is_rtype  in  1  1=R-type (SUB allowed), 0=I-type.
- id_alu_src  in  1  0=B from rs2, 1=B from immediate.
- id_rs1, id_rs2  in  REGW  source register indices.
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_rd  in  REGW  destination index.
- fwd_exmem_we, fwd_memwb_we  in  1  later-stage write enables.
- fwd_exmem_rd, fwd_memwb_rd  in  REGW  later-stage destinations.
- fwd_exmem_data, fwd_memwb_data  in  XLEN  later-stage results.
- flush  in  1  kill the registered instruction and the incoming one.
- ex_valid  out  1  registered instruction valid.
- ex_ready  in  1  EX stage consumes the instruction this cycle.
- ex_a, ex_b  out  XLEN  ALU operands.
- ex_op  out  4  ALU operation code.
- ex_store_data  out  XLEN  forwarded rs2 value (for stores).
- ex_rd  out  REGW  destination.
- ex_illegal  out  1  unsupported operation flagged.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - ex_valid=0, ex_op=ADD (4'b0001), ex_illegal=0;
  - ex_a, ex_b, ex_store_data and ex_rd all 0.
- Release of reset is sampled on the next rising edge.
- id_ready = ~ex_valid | ex_ready (combinational; one-entry skid-free register).
- Accept when id_valid & id_ready & ~flush.
  - At the following rising edge all ex_* outputs load and ex_valid=1.
  - Latency: exactly 1 cycle, from decode to ALU inputs.
- Drain: if ex_ready=1 and no accept occurs, ex_valid clears to 0. The data outputs hold their values.
- Hold: ex_valid=1 & ex_ready=0 → all ex_* outputs hold unchanged; id_ready=0.
- Flush: flush=1 at an edge → ex_valid=0 and no accept that cycle.
  - Flush has priority over a simultaneous accept and over hold.
- Op decode (alu_ctrl_dec):
  - mode 00 → ADD.
  - mode 01 → SUB (4'b0000).
  - mode 10, by funct3:
    - funct3 000 → SUB if id_is_rtype & funct7_5, else ADD;
    - funct3 111 → AND (4'b0010);
    - funct3 110 → OR (4'b0011);
    - funct3 101 with funct7_5=0 → SRL (4'b1100).
  - Any other combination, including mode 11 and SRA (funct3 101, funct7_5=1) → ex_op=ADD, ex_illegal=1.
- Forwarding, per source (rs1 → A; rs2 → store data and B when alu_src=0):
  - Priority: EX/MEM match, then MEM/WB match, then register-file data.
  - A match requires we=1, rd equal to the source index, and rd≠0. x0 is never forwarded.
- B = id_imm when alu_src=1. The immediate is passed at full width; shift-amount truncation is the ALU's job.
- Operands are captured at accept only and are not re-forwarded while held. Load-use and held-operand hazards belong to the hazard unit.

Decomposition:
- Shared package alu_pkg holds:
  - the ALU operation codes: SUB 0000, ADD 0001, AND 0010, OR 0011, SRL 1100;
  - the alu_mode codes;
  - the funct3 constants.
- One combinational sub-module, alu_ctrl_dec: inputs alu_mode, funct3, funct7_5, is_rtype; outputs op and illegal.
- Forwarding muxes and the pipeline register stay in the top module.

Test Plan:
- Reset mid-hold: ex_valid=1, ex_ready=0, assert rst_n=0 asynchronously → ex_valid=0 and ex_op=0001 immediately, without waiting for a clock edge.
- R-type SUB: mode=10, funct3=000, f7_5=1, is_rtype=1, rs1_data=10, rs2_data=3 → next cycle ex_op=0000, ex_a=10, ex_b=3.
- I-type SRL plus illegal SRA:
  - alu_src=1, imm=4, funct3=101, f7_5=0 → ex_op=1100, ex_b=4;
  - f7_5=1 → ex_op=0001, ex_illegal=1.
- Forward priority: rs1=5, both stages writing x5 (exmem_data=0xAA, memwb_data=0xBB) → ex_a=0xAA. With rs1=0 and both stages writing x0 → ex_a=rs1_data.
- Stall then drain:
  - ex_ready=0 for 3 cycles with id_valid=1 → id_ready=0 and ex_* stable throughout.
  - ex_ready=1 → next instruction loads the next cycle.
- Flush collision: flush=1 together with id_valid=1, id_ready=1 → next cycle ex_valid=0 and the incoming instruction is dropped.
